lsu_store_queue: RTL and testbench
==================================

# lsu_store_queue

Parametrised store queue between the LSU M1 stage and the dcache write port. It accepts speculative stores, marks them committed in order on commit-stage request, and drains committed stores oldest-first to the cache. It also provides byte-granular, youngest-wins load forwarding that merges across all live entries, plus optional same-word store coalescing. It replaces the fixed 4-entry, word-granular store buffer.

## Interface
Parameters:
- `SB_SIZE`, 4: entry count; power of two, ≥2.
- `WORD_SIZE`, 32: data width in bits; multiple of 8.
- `ADDR_WIDTH`, 32: physical address width.
- `MERGE_EN`, 1: enables store coalescing into the youngest entry.
- `STRB_W` (derived): `WORD_SIZE/8`.
- `OFF` (derived): `$clog2(STRB_W)`.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `flush_i`, in, 1: discard all uncommitted entries.
- `push_valid_i`, in, 1: store request from M1.
- `push_ready_o`, out, 1: equals `!full_o`.
- `push_addr_i`, in, ADDR_WIDTH: physical address of the store.
- `push_data_i`, in, WORD_SIZE: store data, byte lanes already aligned.
- `push_strb_i`, in, STRB_W: byte write enables.
- `commit_i`, in, 1: mark the oldest uncommitted entry as committed.
- `drain_valid_o`, out, 1: the oldest entry is present and committed.
- `drain_ready_i`, in, 1: the cache has accepted the drain payload.
- `drain_addr_o`, out, ADDR_WIDTH: address of the oldest entry; bits [OFF-1:0] are zero.
- `drain_data_o`, out, WORD_SIZE: data of the oldest entry.
- `drain_strb_o`, out, STRB_W: byte enables of the oldest entry.
- `fwd_addr_i`, in, ADDR_WIDTH: load address to look up.
- `fwd_rmask_i`, in, STRB_W: bytes the load needs.
- `fwd_data_o`, out, WORD_SIZE: merged forwarded data.
- `fwd_strb_o`, out, STRB_W: bytes supplied by the queue.
- `fwd_full_o`, out, 1: every byte in `fwd_rmask_i` is supplied.
- `count_o`, out, $clog2(SB_SIZE)+1: number of live entries.
- `empty_o`, out, 1: no live entries.
- `full_o`, out, 1: `count_o == SB_SIZE`.

## Operation
- State: a circular entry array plus three pointers, each with an extra wrap bit:
  - `head`: oldest entry.
  - `cptr`: first uncommitted entry.
  - `tail`: next free entry.
- Ordering invariant: head ≤ cptr ≤ tail, in modular order.
- Derived values:
  - `count_o = tail - head`.
  - `empty_o` is high when `head == tail`.
  - `drain_valid_o = (head != cptr)`.
- Push (handshake: `push_valid_i & push_ready_o`):
  - `push_strb_i == 0`: accepted as a no-op.
  - Merge: if `MERGE_EN`, the youngest entry (`tail-1`) is uncommitted, its word address `[ADDR_WIDTH-1:OFF]` matches, and `commit_i` is low this cycle, then the push merges into that entry. Bytes with strb set are overwritten and `strb |= push_strb_i`. `tail` is unchanged.
  - Otherwise the push is written at `tail` and `tail` increments.
- Commit: if `commit_i` and `cptr != tail`, `cptr` increments. `commit_i` with no uncommitted entry is ignored.
- Drain: `drain_valid_o & drain_ready_i` increments `head`. The payload stays stable while valid is high and ready is low.
- Flush: `tail <= cptr` after any same-cycle commit is applied.
  - A same-cycle push is dropped.
  - A same-cycle drain completes normally.
  - Committed entries are never discarded.
- Forward (combinational on registered state only; the same-cycle push is not visible):
  - For each byte b, walk entries from oldest to youngest in [head, tail). The youngest entry with a matching word address and `strb[b]` set supplies byte b.
  - `fwd_strb_o = supplied & fwd_rmask_i`.
  - Unsupplied bytes read as 0.
  - `fwd_full_o = ((fwd_strb_o == fwd_rmask_i) && fwd_rmask_i != 0)`.
- Simultaneous push, commit and drain in one cycle are all legal and all take effect.
- Full: `push_ready_o` depends only on registered `count_o`. A push is not accepted in the cycle a drain frees space.

## Timing
- Reset (asynchronous, `rst` high): all pointers are 0.
  - Output values: `push_ready_o=1`, `drain_valid_o=0`, `empty_o=1`, `full_o=0`, `count_o=0`, `fwd_strb_o=0`, `fwd_data_o=0`, `fwd_full_o=0`.
  - Drain outputs are 0 while empty.
- Asserting `rst` mid-operation discards everything immediately, including committed entries. The commit stage must not reset with committed stores outstanding.
- Push latency: an entry accepted at edge N is visible to forwarding and `count_o` after edge N.
- Commit latency: `commit_i` sampled at edge N gives `drain_valid_o` high after N, provided it was the head entry.
- Drain: one entry per cycle when `drain_ready_i` stays high.
- Forward path: zero cycles, combinational from `fwd_addr_i` and `fwd_rmask_i`.

## Test plan
- Fill and wrap (SB_SIZE=4):
  - Push 4 stores at 0x100, 0x104, 0x108, 0x10C with strb=F → `full_o=1`, `push_ready_o=0`.
  - Commit all, drain 2, push 2 more → pointers wrap and the drain order is 0x100, 0x104, 0x108, …
- Byte merge forwarding:
  - Push (0x200, 0x000000AA, strb=1), then (0x200, 0x0000BB00, strb=2), with `MERGE_EN=0`.
  - Forward 0x200 with rmask=3 → `fwd_data_o=0x0000BBAA`, `fwd_full_o=1`.
  - Forward with rmask=F → `fwd_strb_o=3`, `fwd_full_o=0`.
- Coalesce (`MERGE_EN=1`):
  - Push (0x300, 0x11223344, F), then (0x300, 0x55000000, 8) → `count_o=1`, and after commit the drain data is 0x55223344.
  - Repeat with `commit_i` high on the second push cycle → `count_o=2`.
- Flush:
  - Push 3 stores, commit 1, then flush while pushing a fourth → `count_o=1`. Only the committed store drains, and the fourth push is dropped.
- Drain backpressure:
  - Hold `drain_ready_i=0` for 5 cycles with a committed entry → payload stable and `drain_valid_o=1` throughout.
  - Assert `rst` mid-hold → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/lsu_store_queue_if.sv
// Store queue bus bundle: M1 push, commit-stage control, dcache drain port,
// load-forwarding lookup and occupancy status.
interface lsu_store_queue_if #(
  parameter int SB_SIZE    = 4,
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_W = WORD_SIZE / 8;
  localparam int CW     = $clog2(SB_SIZE) + 1;

  logic                  flush_i;
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [ADDR_WIDTH-1:0] push_addr_i;
  logic [WORD_SIZE-1:0]  push_data_i;
  logic [STRB_W-1:0]     push_strb_i;
  logic                  commit_i;
  logic                  drain_valid_o;
  logic                  drain_ready_i;
  logic [ADDR_WIDTH-1:0] drain_addr_o;
  logic [WORD_SIZE-1:0]  drain_data_o;
  logic [STRB_W-1:0]     drain_strb_o;
  logic [ADDR_WIDTH-1:0] fwd_addr_i;
  logic [STRB_W-1:0]     fwd_rmask_i;
  logic [WORD_SIZE-1:0]  fwd_data_o;
  logic [STRB_W-1:0]     fwd_strb_o;
  logic                  fwd_full_o;
  logic [CW-1:0]         count_o;
  logic                  empty_o;
  logic                  full_o;

  // LSU / commit stage / dcache side
  modport master (
    output flush_i, push_valid_i, push_addr_i, push_data_i, push_strb_i,
           commit_i, drain_ready_i, fwd_addr_i, fwd_rmask_i,
    input  push_ready_o, drain_valid_o, drain_addr_o, drain_data_o,
           drain_strb_o, fwd_data_o, fwd_strb_o, fwd_full_o,
           count_o, empty_o, full_o
  );

  // Store queue side
  modport slave (
    input  flush_i, push_valid_i, push_addr_i, push_data_i, push_strb_i,
           commit_i, drain_ready_i, fwd_addr_i, fwd_rmask_i,
    output push_ready_o, drain_valid_o, drain_addr_o, drain_data_o,
           drain_strb_o, fwd_data_o, fwd_strb_o, fwd_full_o,
           count_o, empty_o, full_o
  );
endinterface

// File: rtl/lsu_store_queue.sv
// Store queue between LSU M1 and the dcache write port. Entries live in a
// circular array bounded by head (oldest), cptr (first uncommitted) and
// tail (next free); each pointer carries a wrap bit so full/empty and the
// committed region are distinguishable. Provides byte-granular youngest-wins
// load forwarding and optional coalescing into the youngest open entry.
module lsu_store_queue #(
  parameter int SB_SIZE    = 4,
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter bit MERGE_EN   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  lsu_store_queue_if.slave  sq
);
  localparam int STRB_W = WORD_SIZE / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int PW     = $clog2(SB_SIZE);
  localparam int WA     = ADDR_WIDTH - OFF;

  typedef logic [PW:0] ptr_t;

  ptr_t head, cptr, tail;
  ptr_t cptr_next;
  ptr_t count;

  logic [WA-1:0]        ent_addr [SB_SIZE];
  logic [WORD_SIZE-1:0] ent_data [SB_SIZE];
  logic [STRB_W-1:0]    ent_strb [SB_SIZE];

  logic                 full, empty, drain_valid;
  logic                 has_open;
  logic [PW-1:0]        head_idx, tail_idx, young_idx;
  logic [WA-1:0]        push_word, fwd_word;
  logic                 push_fire, merge_hit, do_merge, do_alloc;
  logic                 do_commit, do_drain;
  logic [WORD_SIZE-1:0] byte_mask;
  logic [WORD_SIZE-1:0] fwd_data;
  logic [STRB_W-1:0]    supplied;
  logic                 unused_bits;

  assign count       = tail - head;
  assign full        = (count == ptr_t'(SB_SIZE));
  assign empty       = (head == tail);
  assign drain_valid = (head != cptr);
  assign has_open    = (cptr != tail);

  assign head_idx  = head[PW-1:0];
  assign tail_idx  = tail[PW-1:0];
  assign young_idx = tail_idx - PW'(1);
  assign push_word = sq.push_addr_i[ADDR_WIDTH-1:OFF];
  assign fwd_word  = sq.fwd_addr_i[ADDR_WIDTH-1:OFF];

  // A flush drops any same-cycle push, and an all-zero strobe is a no-op.
  assign push_fire = sq.push_valid_i && !full && (|sq.push_strb_i) && !sq.flush_i;
  assign merge_hit = MERGE_EN && has_open && !sq.commit_i &&
                     (ent_addr[young_idx] == push_word);
  assign do_merge  = push_fire && merge_hit;
  assign do_alloc  = push_fire && !merge_hit;
  assign do_commit = sq.commit_i && has_open;
  assign do_drain  = drain_valid && sq.drain_ready_i;
  assign cptr_next = do_commit ? cptr + ptr_t'(1) : cptr;

  // Expand the push strobe into a bit mask for partial-word merging
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byte_mask[8*b +: 8] = {8{sq.push_strb_i[b]}};
    end
  end

  // Pointer update; flush rewinds tail to the post-commit cptr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      cptr <= '0;
      tail <= '0;
    end else begin
      if (do_drain) head <= head + ptr_t'(1);
      cptr <= cptr_next;
      if (sq.flush_i)    tail <= cptr_next;
      else if (do_alloc) tail <= tail + ptr_t'(1);
    end
  end

  // Entry storage: allocate at tail or coalesce into the youngest entry
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_addr[tail_idx] <= push_word;
      ent_data[tail_idx] <= sq.push_data_i;
      ent_strb[tail_idx] <= sq.push_strb_i;
    end else if (do_merge) begin
      ent_data[young_idx] <= (ent_data[young_idx] & ~byte_mask) |
                             (sq.push_data_i & byte_mask);
      ent_strb[young_idx] <= ent_strb[young_idx] | sq.push_strb_i;
    end
  end

  // Forwarding: scan oldest to youngest so later matches overwrite earlier
  always_comb begin
    fwd_data = '0;
    supplied = '0;
    for (int i = 0; i < SB_SIZE; i++) begin
      if ((ptr_t'(i) < count) &&
          (ent_addr[PW'(head_idx + PW'(i))] == fwd_word)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (ent_strb[PW'(head_idx + PW'(i))][b]) begin
            supplied[b]        = 1'b1;
            fwd_data[8*b +: 8] = ent_data[PW'(head_idx + PW'(i))][8*b +: 8];
          end
        end
      end
    end
  end

  assign sq.fwd_data_o    = fwd_data;
  assign sq.fwd_strb_o    = supplied & sq.fwd_rmask_i;
  assign sq.fwd_full_o    = ((supplied & sq.fwd_rmask_i) == sq.fwd_rmask_i) &&
                            (|sq.fwd_rmask_i);

  assign sq.drain_valid_o = drain_valid;
  assign sq.drain_addr_o  = drain_valid ? {ent_addr[head_idx], {OFF{1'b0}}} : '0;
  assign sq.drain_data_o  = drain_valid ? ent_data[head_idx] : '0;
  assign sq.drain_strb_o  = drain_valid ? ent_strb[head_idx] : '0;

  assign sq.push_ready_o  = !full;
  assign sq.full_o        = full;
  assign sq.empty_o       = empty;
  assign sq.count_o       = count;

  assign unused_bits = ^{sq.push_addr_i[OFF-1:0], sq.fwd_addr_i[OFF-1:0]};
endmodule

// File: tb/tb_lsu_store_queue.sv
// Bench for lsu_store_queue: one instance with coalescing disabled and one
// with it enabled, driven by identical stimulus and each checked every cycle
// against a list-based model of the queue contents.
module tb_lsu_store_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lsu_store_queue_if #(.SB_SIZE(4), .WORD_SIZE(32), .ADDR_WIDTH(32)) ifn ();
  lsu_store_queue_if #(.SB_SIZE(4), .WORD_SIZE(32), .ADDR_WIDTH(32)) ifm ();

  lsu_store_queue #(.SB_SIZE(4), .WORD_SIZE(32), .ADDR_WIDTH(32), .MERGE_EN(1'b0))
    u_nomerge (.clk(clk), .rst(rst), .sq(ifn));
  lsu_store_queue #(.SB_SIZE(4), .WORD_SIZE(32), .ADDR_WIDTH(32), .MERGE_EN(1'b1))
    u_merge (.clk(clk), .rst(rst), .sq(ifm));

  logic        s_pv, s_cm, s_dr, s_fl;
  logic [31:0] s_a, s_d, s_fa;
  logic [3:0]  s_st, s_rm;

  assign ifn.push_valid_i  = s_pv;  assign ifm.push_valid_i  = s_pv;
  assign ifn.push_addr_i   = s_a;   assign ifm.push_addr_i   = s_a;
  assign ifn.push_data_i   = s_d;   assign ifm.push_data_i   = s_d;
  assign ifn.push_strb_i   = s_st;  assign ifm.push_strb_i   = s_st;
  assign ifn.commit_i      = s_cm;  assign ifm.commit_i      = s_cm;
  assign ifn.drain_ready_i = s_dr;  assign ifm.drain_ready_i = s_dr;
  assign ifn.flush_i       = s_fl;  assign ifm.flush_i       = s_fl;
  assign ifn.fwd_addr_i    = s_fa;  assign ifm.fwd_addr_i    = s_fa;
  assign ifn.fwd_rmask_i   = s_rm;  assign ifm.fwd_rmask_i   = s_rm;

  // Model: index 0 of each list is the oldest entry; m_com entries are committed
  logic [31:0] m_addr [2][4];
  logic [31:0] m_data [2][4];
  logic [3:0]  m_strb [2][4];
  int          m_cnt  [2];
  int          m_com  [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_com[k] = 0;
    end
  endtask

  // Forwarding model: for each byte take the first hit searching youngest-first
  task automatic fwdModel(input int k, input logic [31:0] fa, input logic [3:0] rm,
                          output logic [31:0] fd, output logic [3:0] fs,
                          output logic ff);
    logic [3:0] sup;
    fd  = '0;
    sup = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = m_cnt[k] - 1; i >= 0; i--) begin
        if (m_addr[k][i][31:2] == fa[31:2] && m_strb[k][i][b]) begin
          fd[8*b +: 8] = m_data[k][i][8*b +: 8];
          sup[b] = 1'b1;
          break;
        end
      end
    end
    fs = sup & rm;
    ff = (fs == rm) && (rm != 4'h0);
  endtask

  // Advance the model by one clock edge using the inputs held this cycle
  task automatic modelStep(input int k);
    int   cnt, com;
    logic pf, cmt, drn;
    cnt = m_cnt[k];
    com = m_com[k];
    pf  = s_pv && (cnt < 4) && (s_st != 4'h0) && !s_fl;
    cmt = s_cm && (com < cnt);
    drn = (com > 0) && s_dr;
    if (pf) begin
      if (k == 1 && com < cnt && !s_cm && m_addr[k][cnt-1][31:2] == s_a[31:2]) begin
        for (int b = 0; b < 4; b++)
          if (s_st[b]) m_data[k][cnt-1][8*b +: 8] = s_d[8*b +: 8];
        m_strb[k][cnt-1] = m_strb[k][cnt-1] | s_st;
      end else begin
        m_addr[k][cnt] = {s_a[31:2], 2'b00};
        m_data[k][cnt] = s_d;
        m_strb[k][cnt] = s_st;
        cnt++;
      end
    end
    if (cmt) com++;
    if (s_fl) cnt = com;
    if (drn) begin
      for (int i = 0; i < 3; i++) begin
        m_addr[k][i] = m_addr[k][i+1];
        m_data[k][i] = m_data[k][i+1];
        m_strb[k][i] = m_strb[k][i+1];
      end
      cnt--;
      com--;
    end
    m_cnt[k] = cnt;
    m_com[k] = com;
  endtask

  task automatic checkInst(input int k, input logic pr, input logic dv,
                           input logic [31:0] da, input logic [31:0] dd,
                           input logic [3:0] ds, input logic [2:0] cnt,
                           input logic emp, input logic ful,
                           input logic [31:0] fd, input logic [3:0] fs,
                           input logic ff);
    string       p;
    logic [31:0] efd;
    logic [3:0]  efs;
    logic        eff, edv;
    p   = (k == 1) ? "merge" : "nomerge";
    edv = m_com[k] > 0;
    fwdModel(k, s_fa, s_rm, efd, efs, eff);
    checkOutput({p, ".push_ready"},  pr,  m_cnt[k] != 4);
    checkOutput({p, ".drain_valid"}, dv,  edv);
    checkOutput({p, ".drain_addr"},  da,  edv ? m_addr[k][0] : 32'h0);
    checkOutput({p, ".drain_data"},  dd,  edv ? m_data[k][0] : 32'h0);
    checkOutput({p, ".drain_strb"},  ds,  edv ? m_strb[k][0] : 4'h0);
    checkOutput({p, ".count"},       cnt, m_cnt[k]);
    checkOutput({p, ".empty"},       emp, m_cnt[k] == 0);
    checkOutput({p, ".full"},        ful, m_cnt[k] == 4);
    checkOutput({p, ".fwd_data"},    fd,  efd);
    checkOutput({p, ".fwd_strb"},    fs,  efs);
    checkOutput({p, ".fwd_full"},    ff,  eff);
  endtask

  task automatic checkAll();
    checkInst(0, ifn.push_ready_o, ifn.drain_valid_o, ifn.drain_addr_o,
              ifn.drain_data_o, ifn.drain_strb_o, ifn.count_o, ifn.empty_o,
              ifn.full_o, ifn.fwd_data_o, ifn.fwd_strb_o, ifn.fwd_full_o);
    checkInst(1, ifm.push_ready_o, ifm.drain_valid_o, ifm.drain_addr_o,
              ifm.drain_data_o, ifm.drain_strb_o, ifm.count_o, ifm.empty_o,
              ifm.full_o, ifm.fwd_data_o, ifm.fwd_strb_o, ifm.fwd_full_o);
  endtask

  // One cycle: drive at the falling edge, check, then let the rising edge act
  task automatic applyStimulus(input logic pv, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] st,
                               input logic cm, input logic dr, input logic fl,
                               input logic [31:0] fa, input logic [3:0] rm);
    @(negedge clk);
    s_pv = pv; s_a = a; s_d = d; s_st = st;
    s_cm = cm; s_dr = dr; s_fl = fl; s_fa = fa; s_rm = rm;
    #1;
    checkAll();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    applyStimulus(1'b1, a, d, st, 1'b0, 1'b0, 1'b0, a, 4'hF);
  endtask

  task automatic idle(input logic cm, input logic dr, input logic [31:0] fa,
                      input logic [3:0] rm);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, cm, dr, 1'b0, fa, rm);
  endtask

  task automatic doReset();
    @(negedge clk);
    s_pv = 1'b0; s_cm = 1'b0; s_dr = 1'b0; s_fl = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    s_pv = 1'b0; s_a = '0; s_d = '0; s_st = '0; s_cm = 1'b0;
    s_dr = 1'b0; s_fl = 1'b0; s_fa = '0; s_rm = 4'hF;
    modelReset();
    doReset();

    // Reset state
    idle(1'b0, 1'b0, 32'h100, 4'hF);

    // Fill, wrap and drain order
    push(32'h100, 32'hA0A0A0A0, 4'hF);
    push(32'h104, 32'hA1A1A1A1, 4'hF);
    push(32'h108, 32'hA2A2A2A2, 4'hF);
    push(32'h10C, 32'hA3A3A3A3, 4'hF);
    push(32'h110, 32'hDEADDEAD, 4'hF);
    #1;
    checkOutput("fill.full", ifn.full_o, 1'b1);
    checkOutput("fill.push_ready", ifm.push_ready_o, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 32'h104, 4'hF);
    #1;
    checkOutput("fill.first_drain", ifn.drain_addr_o, 32'h100);
    idle(1'b0, 1'b1, 32'h100, 4'hF);
    idle(1'b0, 1'b1, 32'h108, 4'hF);
    push(32'h110, 32'hB0B0B0B0, 4'hF);
    push(32'h114, 32'hB1B1B1B1, 4'hF);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1, 32'h110, 4'hF);

    // Byte-lane forwarding across two separate entries
    doReset();
    push(32'h200, 32'h000000AA, 4'h1);
    push(32'h200, 32'h0000BB00, 4'h2);
    idle(1'b0, 1'b0, 32'h200, 4'h3);
    #1;
    checkOutput("fwd.data", ifn.fwd_data_o, 32'h0000BBAA);
    checkOutput("fwd.full", ifn.fwd_full_o, 1'b1);
    checkOutput("nomerge.count2", ifn.count_o, 3'd2);
    idle(1'b0, 1'b0, 32'h200, 4'hF);
    #1;
    checkOutput("fwd.strb_partial", ifn.fwd_strb_o, 4'h3);
    checkOutput("fwd.full_partial", ifn.fwd_full_o, 1'b0);

    // Coalescing into the youngest entry
    doReset();
    push(32'h300, 32'h11223344, 4'hF);
    push(32'h300, 32'h55000000, 4'h8);
    #1;
    checkOutput("coal.count", ifm.count_o, 3'd1);
    idle(1'b1, 1'b0, 32'h300, 4'hF);
    #1;
    checkOutput("coal.drain_data", ifm.drain_data_o, 32'h55223344);
    idle(1'b0, 1'b1, 32'h300, 4'hF);
    doReset();
    push(32'h300, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 32'h300, 32'h55000000, 4'h8, 1'b1, 1'b0, 1'b0, 32'h300, 4'hF);
    #1;
    checkOutput("coal.commit_count", ifm.count_o, 3'd2);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, 32'h300, 4'hF);

    // Flush keeps committed stores and drops the same-cycle push
    doReset();
    push(32'h500, 32'h50505050, 4'hF);
    push(32'h504, 32'h51515151, 4'hF);
    push(32'h508, 32'h52525252, 4'hF);
    idle(1'b1, 1'b0, 32'h504, 4'hF);
    applyStimulus(1'b1, 32'h50C, 32'h53535353, 4'hF, 1'b0, 1'b0, 1'b1, 32'h50C, 4'hF);
    #1;
    checkOutput("flush.count", ifn.count_o, 3'd1);
    checkOutput("flush.drain_addr", ifm.drain_addr_o, 32'h500);
    idle(1'b0, 1'b1, 32'h500, 4'hF);
    idle(1'b0, 1'b1, 32'h50C, 4'hF);

    // Drain backpressure, then asynchronous reset in the middle of the hold
    doReset();
    push(32'h600, 32'hCAFEF00D, 4'hF);
    idle(1'b1, 1'b0, 32'h600, 4'hF);
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b0, 32'h600, 4'hF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("areset.push_ready", ifn.push_ready_o, 1'b1);
    checkOutput("areset.drain_valid", ifn.drain_valid_o, 1'b0);
    checkOutput("areset.empty", ifm.empty_o, 1'b1);
    checkOutput("areset.count", ifm.count_o, 3'd0);
    checkOutput("areset.fwd_data", ifn.fwd_data_o, 32'h0);
    checkOutput("areset.fwd_strb", ifm.fwd_strb_o, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Randomized traffic concentrated on four words to provoke merges/hits
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra, rfa;
      ra  = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      rfa = 32'h400 + 32'($urandom_range(0, 4) * 4);
      applyStimulus(($urandom_range(0, 3) != 0), ra, $urandom,
                    ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 24) == 0), rfa, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
